// File: rtl/gearbox_serializer.sv
// Pops 20-bit gearbox words and emits them LSB-first, LANES bits per cycle.
// Optional underrun counter: define GEARBOX_SERIALIZER_UNDERRUN_CNT_EN.
module gearbox_serializer #(
    parameter int          LANES        = 4,
    parameter logic [19:0] IDLE_PATTERN = 20'hC14FA
) (
    input  logic             clk,
    input  logic             res,
    input  logic             valid_in,
    input  logic [19:0]      data_in,
    output logic             shift_out,
    output logic [LANES-1:0] ser_out,
    output logic             ser_valid,
    output logic             word_start
`ifdef GEARBOX_SERIALIZER_UNDERRUN_CNT_EN
    ,
    output logic [15:0]      underrun_cnt
`endif
);

    localparam int N  = 20 / LANES;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    generate
        if (LANES < 1 || LANES > 20 || (20 % LANES) != 0) begin : g_bad_lanes
            $error("gearbox_serializer: LANES must divide 20");
        end
    endgenerate

    logic [CW-1:0] cnt_q, cnt_d;
    logic [19:0]   shreg_q, shreg_d;
    logic          ser_valid_q, ser_valid_d;
    logic          word_start_q, word_start_d;
    logic          boundary;

    assign boundary  = (cnt_q == LAST);
    assign shift_out = valid_in & boundary & ~res;

    always_comb begin
        cnt_d        = cnt_q + CW'(1);
        shreg_d      = shreg_q >> LANES;
        ser_valid_d  = ser_valid_q;
        word_start_d = 1'b0;
        if (boundary) begin
            cnt_d        = '0;
            shreg_d      = shift_out ? data_in : IDLE_PATTERN;
            ser_valid_d  = shift_out;
            word_start_d = shift_out;
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            cnt_q        <= LAST;
            shreg_q      <= '0;
            ser_valid_q  <= 1'b0;
            word_start_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            shreg_q      <= shreg_d;
            ser_valid_q  <= ser_valid_d;
            word_start_q <= word_start_d;
        end
    end

    assign ser_out    = shreg_q[LANES-1:0];
    assign ser_valid  = ser_valid_q;
    assign word_start = word_start_q;

`ifdef GEARBOX_SERIALIZER_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt_q, underrun_cnt_d;

    // Only a data word followed by an idle boundary counts as an underrun.
    always_comb begin
        underrun_cnt_d = underrun_cnt_q;
        if (boundary && ser_valid_q && !shift_out && underrun_cnt_q != 16'hFFFF)
            underrun_cnt_d = underrun_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (res) underrun_cnt_q <= '0;
        else     underrun_cnt_q <= underrun_cnt_d;
    end

    assign underrun_cnt = underrun_cnt_q;
`endif

endmodule

// File: doc/gearbox_serializer.md
Name: gearbox_serializer

Overview:
- Downstream consumer of the 16->20 gearbox, in the gearbox's clk2 domain.
- Pops 20-bit words through the gearbox's valid_out/shift_out handshake and emits them LSB-first, LANES bits per cycle, on a parallel lane bus.
- Free-running slice counter keeps word boundaries fixed.
- When no word is available at a boundary, emits a 20-bit idle pattern, so the line never stalls.

Parameters:
- LANES, 4, output bits per cycle; must divide 20 (1,2,4,5,10,20); any other value is an elaboration error.
- IDLE_PATTERN, 20'hC14FA, idle word (K28.5 RD-/RD+ pair), emitted LSB-first like data.

Ports:
- clk  in  1  clock (clk2 domain of gearbox)
- res  in  1  reset; one clock; reset is synchronous and active-high
- valid_in  in  1  gearbox valid_out: data_in holds a word
- data_in  in  20  gearbox data_out
- shift_out  out  1  pop strobe to gearbox shift_out (combinational)
- ser_out  out  LANES  current output slice
- ser_valid  out  1  1 = ser_out carries data, 0 = idle pattern
- word_start  out  1  1 on first slice of every data word

Behaviour:
- N = 20/LANES slices per word; cnt is ceil(log2 N) bits (min 1), counts 0..N-1 and wraps; runs every cycle, data or idle.
- Reset (res=1 at posedge):
  - cnt <= N-1; shreg <= 0; ser_valid <= 0; word_start <= 0.
  - ser_out = 0 during and after reset, until the first load.
  - shift_out forced 0 while res=1.
- shift_out = valid_in & (cnt==N-1) & ~res. Pops occur only at word boundaries; at most one pop per N cycles.
- Boundary edge (cnt==N-1):
  - shift_out=1: shreg <= data_in, ser_valid <= 1, word_start <= 1.
  - shift_out=0: shreg <= IDLE_PATTERN, ser_valid <= 0, word_start <= 0.
  - cnt <= 0.
- Other edges: shreg <= shreg >> LANES (zero fill), word_start <= 0, ser_valid held, cnt <= cnt+1.
- ser_out = shreg[LANES-1:0], a register output with no combinational path from inputs.
- Latency: word popped in cycle t appears as slices 0..N-1 in cycles t+1..t+N.
- Back-to-back words: gapless, no idle slice between them.
- valid_in rising mid-word: ignored until cnt==N-1; data_in is not sampled early.
- valid_in dropping mid-word: no effect; the current word completes.
- LANES=20: N=1, cnt constant 0, a pop is possible every cycle.
- Reset mid-word: the word is discarded. The gearbox word is not popped again; whatever is pending stays in the gearbox.
- No FSM beyond the cnt/ser_valid pair. Mode is IDLE when ser_valid=0, DATA when ser_valid=1; the mode is chosen only at boundaries.

Optional Feature:
- Macro: GEARBOX_SERIALIZER_UNDERRUN_CNT_EN.
- Defined:
  - Adds output port underrun_cnt, 16 bits, reset to 0.
  - Increments at each boundary edge where ser_valid==1 and shift_out==0, i.e. a data stream falls into idle.
  - Saturates at 16'hFFFF.
  - Idle-to-idle boundaries do not count; the first idle after reset does not count.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Idle after reset: LANES=4, valid_in=0, release res -> ser_valid=0; ser_out cycles A,F,4,1,C repeating; shift_out never 1.
- Single word: valid_in=1 with data_in=20'hABCDE in first cycle after reset -> shift_out=1 that cycle only. Next 5 cycles: ser_out E,D,C,B,A, ser_valid=1, word_start=1 on slice E only. Then idle A,F,4,1,C with ser_valid=0.
- Back-to-back: valid_in held 1 with words 20'h12345 then 20'h6789A -> shift_out pulses every 5th cycle. Output 5,4,3,2,1,A,9,8,7,6 with no gap; word_start on slices 5 and A.
- Mid-word arrival: valid_in asserted when cnt==1 -> shift_out stays 0 until cnt==4; word first appears in the cycle after that boundary.
- Reset mid-word: res=1 during slice 2 of 20'hFFFFF -> next cycle ser_out=0, ser_valid=0, word_start=0. After release, the idle pattern or the next word starts cleanly at slice 0.
- With GEARBOX_SERIALIZER_UNDERRUN_CNT_EN: word, idle boundary, word, idle boundary -> underrun_cnt 0->1->2. Forced to 16'hFFFF plus a further underrun -> stays 16'hFFFF. res -> 0.
